ring_token_arbiter: RTL
=======================

Name: ring_token_arbiter

Overview:
- Round-robin arbiter for N requesters built on a one-hot token ring.
- Moves the token with hold / rotate-forward / rotate-backward commands, the same control set as the team's 3-bit rotating ring register.
- Owns an internal token register and exports the per-cycle rotate commands (f_o / r_o), so an external ring register can be slaved to it in lock-step.
- Grants the requester whose position holds the token, with a bounded hold time.

Parameters:
- N, 3, number of requesters / ring width; N >= 2.
- HOLD_MAX, 8, maximum consecutive grant cycles before forced release; >= 1.
- CW, 4, hold-counter width; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request, one bit per requester, level-sensitive.
- done  in  N  release pulse from the granted requester; other bits ignored.
- grant  out  N  one-hot grant, registered; all zero when nothing is granted.
- token  out  N  current one-hot token register.
- f_o  out  1  rotate-forward command: token index +1 (mod N) at the next edge.
- r_o  out  1  rotate-backward command: token index -1 (mod N) at the next edge.
- busy  out  1  high in the SEEK and GRANT states.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE; token = one-hot at index 0 (3'b001 for N=3).
  - grant = 0, f_o = 0, r_o = 0, busy = 0, hold counter = 0, target = 0.
- Reset mid-operation: everything returns to the reset values above at once, including during SEEK and GRANT.
- Token update rules:
  - f_o = 1: token[i] <= token[(i-1) mod N].
  - r_o = 1: token[i] <= token[(i+1) mod N].
  - Otherwise the token holds.
  - f_o and r_o are never 1 together.
- IDLE, when req != 0:
  - Search order is p+1, p+2, ..., p+N (mod N), where p is the current token index. The current holder is therefore checked last.
  - The first requesting index becomes target (latched).
  - Forward distance d = (target - p) mod N.
  - d == 0: go to GRANT next edge.
  - d != 0: go to SEEK; direction = forward if d <= N/2 (integer division), else backward.
  - req == 0: stay in IDLE with all outputs 0.
- SEEK:
  - f_o or r_o (the latched direction) is asserted every cycle; the token steps once per cycle.
  - The step count is min(d, N-d).
  - When the post-step token equals target, the next state is evaluated at that same edge:
    - if req[target] == 1, go to GRANT;
    - else go to IDLE (no grant).
  - req changes during SEEK do not alter target.
- GRANT:
  - grant = token, asserted from the first GRANT cycle.
  - The hold counter counts grant cycles starting at 1.
  - Exit to IDLE when any of the following holds:
    - done[target] == 1;
    - req[target] == 0;
    - the counter reaches HOLD_MAX.
  - grant deasserts in the cycle after the exit condition is sampled, so grant is high at most HOLD_MAX cycles.
  - The token does not move on exit, so the next search starts after the just-served index (fairness).
- Latency from req sampled in IDLE to grant high:
  - 1 cycle + min(d, N-d) SEEK cycles.
  - Minimum one IDLE cycle between consecutive grants.
- Simultaneous events:
  - done and HOLD_MAX on the same cycle: a single exit.
  - done bits for non-target indices: ignored.
- Width rules:
  - Index arithmetic is mod N, done in clog2(N)-bit plus carry.
  - The counter saturates and clears on entering IDLE.

Test Plan:
1. Assert rst_n=0 mid-SEEK (N=3, token 001, r_o=1) -> same cycle: token=001, grant=000, f_o=r_o=0, busy=0; after release, IDLE.
2. After reset, req=001 held, done[0] pulsed on 3rd grant cycle -> grant=001 from cycle 2; f_o=r_o=0 throughout; grant=000 one cycle after done; busy mirrors grant.
3. Token 001, req=010 -> one cycle f_o=1, token 010, then grant=010 (req-to-grant 2 cycles).
4. Token 001, req=100 -> one cycle r_o=1 (d=2>1), token 100, grant=100.
5. Token 001, req=111 constant, done pulse each grant -> grant order 010, 100, 001, 010, each preceded by exactly one f_o cycle.
6. req=010 held, done never pulsed, HOLD_MAX=8 -> grant=010 exactly 8 cycles, 1 IDLE cycle, re-grant 010 with no rotation.

Source files
------------

// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter: round-robin arbiter that moves a one-hot token around
// a ring with hold/forward/backward steps and grants the token holder.
// f_o/r_o are exported so an external ring register can follow in lock-step.
module ring_token_arbiter #(
    parameter int unsigned N        = 3,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CW       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic [N-1:0] token,
    output logic         f_o,
    output logic         r_o,
    output logic         busy
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEK  = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_token;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_target;
    logic [N-1:0]    r_grant;
    logic            r_f_o;
    logic            r_r_o;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_tok_fwd;
    logic [N-1:0]    w_tok_bwd;
    logic [N-1:0]    w_step_tok;
    logic [IW-1:0]   w_idx_fwd;
    logic [IW-1:0]   w_idx_bwd;
    logic [IW-1:0]   w_step_idx;
    logic            w_found;
    logic [IW-1:0]   w_tgt;
    logic [IW-1:0]   w_dist;
    logic [IW:0]     w_sum;
    logic            w_fwd;
    logic            w_hold_exit;

    // Neighbouring token/index values for one step in either direction
    always_comb begin
        w_tok_fwd  = {r_token[N-2:0], r_token[N-1]};
        w_tok_bwd  = {r_token[0], r_token[N-1:1]};
        w_idx_fwd  = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);
        w_idx_bwd  = (r_idx == '0) ? IW'(N - 1) : r_idx - IW'(1);
        w_step_tok = r_f_o ? w_tok_fwd : w_tok_bwd;
        w_step_idx = r_f_o ? w_idx_fwd : w_idx_bwd;
    end

    // First requester after the current holder; the holder itself is checked last
    always_comb begin
        w_found = 1'b0;
        w_tgt   = '0;
        w_dist  = '0;
        w_sum   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_sum = (IW+1)'(r_idx) + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            if (!w_found && req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_tgt   = w_sum[IW-1:0];
                w_dist  = (k == N) ? '0 : IW'(k);
            end
        end
    end

    // Shortest direction to the target and release condition of a grant
    always_comb begin
        w_fwd       = (w_dist <= IW'(N / 2));
        w_hold_exit = done[r_target] | ~req[r_target] | (r_cnt >= CW'(HOLD_MAX));
    end

    // Arbitration state machine, token ring and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_token  <= N'(1);
            r_idx    <= '0;
            r_target <= '0;
            r_grant  <= '0;
            r_f_o    <= 1'b0;
            r_r_o    <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_f_o) begin
                r_token <= w_tok_fwd;
                r_idx   <= w_idx_fwd;
            end else if (r_r_o) begin
                r_token <= w_tok_bwd;
                r_idx   <= w_idx_bwd;
            end

            case (r_state)
                S_IDLE: begin
                    r_grant <= '0;
                    r_f_o   <= 1'b0;
                    r_r_o   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    if (w_found) begin
                        r_target <= w_tgt;
                        r_busy   <= 1'b1;
                        if (w_dist == '0) begin
                            r_state <= S_GRANT;
                            r_grant <= r_token;
                            r_cnt   <= CW'(1);
                        end else begin
                            r_state <= S_SEEK;
                            r_f_o   <= w_fwd;
                            r_r_o   <= ~w_fwd;
                        end
                    end
                end
                S_SEEK: begin
                    if (w_step_idx == r_target) begin
                        r_f_o <= 1'b0;
                        r_r_o <= 1'b0;
                        if (req[r_target]) begin
                            r_state <= S_GRANT;
                            r_grant <= w_step_tok;
                            r_cnt   <= CW'(1);
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_GRANT: begin
                    if (w_hold_exit) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_f_o   <= 1'b0;
                    r_r_o   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign token = r_token;
    assign f_o   = r_f_o;
    assign r_o   = r_r_o;
    assign busy  = r_busy;

endmodule
